// File: rtl/parameters_if.sv
// Data-side bundle of the byte register: load enable, write data and stored value.
//   Enbar    : load enable, active-low (driven by master)
//   new_data : byte to capture on the next ClkN falling edge (driven by master)
//   register : current stored value (driven by slave)
interface parameters_if #(
   parameter int unsigned WIDTH = 8
);
   logic             Enbar;
   logic [WIDTH-1:0] new_data;
   logic [WIDTH-1:0] register;

   modport master (output Enbar, output new_data, input register);
   modport slave  (input Enbar, input new_data, output register);
endinterface

// File: rtl/parameters.sv
// Byte storage register captured on the falling edge of ClkN.
//   ClkN : clock, state changes on the 1->0 edge only
//   ClrN : asynchronous active-high clear, overrides everything
//   bus  : slave side of parameters_if (Enbar, new_data in; register out)
module parameters #(
   parameter int unsigned         WIDTH       = 8,
   parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic        ClkN,
   input  logic        ClrN,
   parameters_if.slave bus
);

   logic [WIDTH-1:0] register_q;

   // Storage flops: clear wins over any falling edge; Enbar=0 loads, Enbar=1 holds.
   always_ff @(negedge ClkN or posedge ClrN) begin
      if (ClrN) begin
         register_q <= RESET_VALUE;
      end else if (!bus.Enbar) begin
         register_q <= bus.new_data;
      end
   end

   assign bus.register = register_q;

endmodule

// File: tb/tb_parameters.sv
// Directed bench for the falling-edge byte register with async clear.
module tb_parameters;

   localparam int unsigned WIDTH = 8;

   logic ClkN;
   logic ClrN;
   int   checks = 0;
   int   errors = 0;

   // Expected register value, updated by the driver from the behavioural rules.
   logic [WIDTH-1:0] exp_q;
   bit               model_valid = 0;
   bit               done = 0;

   parameters_if #(.WIDTH(WIDTH)) bus ();

   parameters #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
      .ClkN (ClkN),
      .ClrN (ClrN),
      .bus  (bus.slave)
   );

   initial begin
      ClkN = 1'b0;
      forever #10 ClkN = ~ClkN;
   end

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: register=%h expected=%h at t=%0t", name, act, want, $time);
      end
   endtask

   // Compare process: mid-high phase, well away from the active falling edge.
   initial begin
      while (!done) begin
         @(posedge ClkN);
         #1;
         if (model_valid && !done) check("model", bus.register, exp_q);
      end
   end

   // Model rule applied at each falling edge.
   task automatic model_edge();
      if (ClrN) exp_q = 8'h00;
      else if (!bus.Enbar) exp_q = bus.new_data;
   endtask

   // One full cycle: apply inputs in the high phase, then pass the falling edge.
   task automatic step(input logic clr, input logic enbar, input logic [WIDTH-1:0] data);
      @(posedge ClkN);
      #2;
      ClrN         = clr;
      bus.Enbar    = enbar;
      bus.new_data = data;
      if (clr) exp_q = 8'h00;
      @(negedge ClkN);
      model_edge();
      #1;
   endtask

   typedef struct {
      logic             clr;
      logic             enbar;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] want;
   } vec_t;

   vec_t vecs[$];

   initial begin
      ClrN         = 1'b1;
      bus.Enbar    = 1'b0;
      bus.new_data = 8'h55;
      exp_q        = 8'h00;
      #1;
      model_valid  = 1;
      check("clear_at_start", bus.register, 8'h00);

      // Clear held: loads ignored; then hold with Enbar=1.
      vecs = '{
         '{1'b1, 1'b0, 8'h55, 8'h00}, '{1'b1, 1'b0, 8'h55, 8'h00}, '{1'b1, 1'b0, 8'h55, 8'h00},
         '{1'b0, 1'b1, 8'h55, 8'h00}, '{1'b0, 1'b1, 8'h55, 8'h00}, '{1'b0, 1'b1, 8'h55, 8'h00}
      };
      foreach (vecs[i]) begin
         step(vecs[i].clr, vecs[i].enbar, vecs[i].data);
         check("vec_clear_hold", bus.register, vecs[i].want);
      end

      // Enbar dropped mid-low phase: no change at rising edge, load at falling edge.
      #5;
      bus.Enbar = 1'b0;
      @(posedge ClkN);
      #1;
      check("no_load_on_rise", bus.register, 8'h00);
      @(negedge ClkN);
      model_edge();
      #1;
      check("load_55", bus.register, 8'h55);

      // new_data changed while ClkN high: stays until falling edge.
      @(posedge ClkN);
      #2;
      bus.new_data = 8'hAA;
      #5;
      check("hold_before_edge", bus.register, 8'h55);
      @(negedge ClkN);
      model_edge();
      #1;
      check("load_aa", bus.register, 8'hAA);

      // Hold with toggling data, then several distinct loads, then Enbar pulsed between edges.
      vecs = '{
         '{1'b0, 1'b1, 8'h0F, 8'hAA}, '{1'b0, 1'b1, 8'hF0, 8'hAA},
         '{1'b0, 1'b1, 8'h0F, 8'hAA}, '{1'b0, 1'b1, 8'hF0, 8'hAA},
         '{1'b0, 1'b0, 8'h01, 8'h01}, '{1'b0, 1'b0, 8'h80, 8'h80},
         '{1'b0, 1'b0, 8'hFF, 8'hFF}, '{1'b0, 1'b1, 8'h00, 8'hFF},
         '{1'b0, 1'b0, 8'h00, 8'h00}, '{1'b0, 1'b0, 8'hAA, 8'hAA}
      };
      foreach (vecs[i]) begin
         step(vecs[i].clr, vecs[i].enbar, vecs[i].data);
         check("vec_load_hold", bus.register, vecs[i].want);
      end

      // Enbar low only between edges: register must hold.
      bus.Enbar    = 1'b1;
      bus.new_data = 8'h3C;
      #3;
      bus.Enbar = 1'b0;
      #3;
      bus.Enbar = 1'b1;
      @(negedge ClkN);
      model_edge();
      #1;
      check("enbar_glitch_hold", bus.register, 8'hAA);

      // Clear raised mid-low phase with Enbar=0: immediate clear, held while asserted.
      #4;
      bus.Enbar    = 1'b0;
      bus.new_data = 8'h33;
      ClrN         = 1'b1;
      exp_q        = 8'h00;
      #1;
      check("clear_immediate", bus.register, 8'h00);
      @(negedge ClkN);
      model_edge();
      #1;
      check("clear_held_1", bus.register, 8'h00);
      @(negedge ClkN);
      model_edge();
      #1;
      check("clear_held_2", bus.register, 8'h00);

      // Clear released just after a falling edge: stays cleared until the next edge loads.
      ClrN = 1'b0;
      #2;
      check("after_release", bus.register, 8'h00);
      @(negedge ClkN);
      model_edge();
      #1;
      check("load_after_clear", bus.register, 8'h33);

      step(1'b0, 1'b0, 8'hC3);
      check("final_load", bus.register, 8'hC3);

      done = 1;
      @(posedge ClkN);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
